// File: rtl/puzzle_route_executor.sv
// -----------------------------------------------------------------------------
// puzzle_route_executor
//
// Bus initiator that replays a stored move route against a 3x3 sliding-puzzle
// board held in a shared 256x8 memory. The initiator first scans the board for
// the blank (value 0). It then fetches route bytes one at a time. Each legal
// move swaps the blank with its neighbour in two write cycles. The final board
// is left in memory.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   start       begin execution (sampled only when not busy)
//   mem_addr    memory address
//   mem_wdata   memory write data
//   mem_we      memory write enable (write lands at clk edge)
//   mem_rdata   memory read data, combinational from mem_addr
//   busy        high while executing
//   done        high after successful completion, held until next start
//   error       high after abort, held until next start
//   err_code    0 none, 1 no blank, 2 bad code, 3 off-board move
//   moves_done  number of completed swaps
//   blank_pos   current blank index 0..8
// -----------------------------------------------------------------------------
module puzzle_route_executor #(
    parameter int BOARD_BASE = 0,
    parameter int ROUTE_BASE = 16,
    parameter int ROUTE_LEN  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [5:0] moves_done,
    output logic [3:0] blank_pos
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FETCH,
        S_RD_NB,
        S_WR_BLANK,
        S_WR_NB,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] BOARD_A   = 8'(BOARD_BASE);
    localparam logic [7:0] ROUTE_A   = 8'(ROUTE_BASE);
    localparam logic [5:0] ROUTE_END = 6'(ROUTE_LEN);

    localparam logic [1:0] ERR_NO_BLANK = 2'd1;
    localparam logic [1:0] ERR_BAD_CODE = 2'd2;
    localparam logic [1:0] ERR_OFF_EDGE = 2'd3;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_scan;
    logic [3:0] r_blank;
    logic [3:0] r_nb;
    logic [5:0] r_idx;
    logic [5:0] r_moves;
    logic [7:0] r_tile;
    logic       r_done;
    logic       r_error;
    logic [1:0] r_err_code;

    logic       w_route_end;
    logic [3:0] w_nb;
    logic       w_off_board;
    logic [1:0] w_err_code;
    logic       w_busy;

    assign w_route_end = (r_idx == ROUTE_END);

    // Neighbour of the blank for the route byte currently on mem_rdata.
    // Row and column edges are detected directly from the index. This keeps a
    // move off column 2 from wrapping onto column 0 of the next row.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        w_nb        = r_blank;
        w_off_board = 1'b0;
        case (mem_rdata)
            8'd1: begin
                w_off_board = (r_blank < 4'd3);
                w_nb        = r_blank - 4'd3;
            end
            8'd2: begin
                w_off_board = (r_blank > 4'd5);
                w_nb        = r_blank + 4'd3;
            end
            8'd3: begin
                w_off_board = (r_blank == 4'd0) || (r_blank == 4'd3) || (r_blank == 4'd6);
                w_nb        = r_blank - 4'd1;
            end
            8'd4: begin
                w_off_board = (r_blank == 4'd2) || (r_blank == 4'd5) || (r_blank == 4'd8);
                w_nb        = r_blank + 4'd1;
            end
            default: ;
        endcase
    end

    // Next state and bus outputs.
    always_comb begin
        w_next     = r_state;
        w_err_code = 2'd0;
        w_busy     = 1'b1;
        mem_addr   = 8'd0;
        mem_wdata  = 8'd0;
        mem_we     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                w_busy = 1'b0;
                if (start) w_next = S_SCAN;
            end
            S_SCAN: begin
                mem_addr = BOARD_A + {4'd0, r_scan};
                if (mem_rdata == 8'd0) begin
                    w_next = S_FETCH;
                end else if (r_scan == 4'd8) begin
                    w_next     = S_ERR;
                    w_err_code = ERR_NO_BLANK;
                end
            end
            S_FETCH: begin
                // A full route finishes without touching the byte past its end.
                if (w_route_end) begin
                    w_next = S_DONE;
                end else begin
                    mem_addr = ROUTE_A + {2'd0, r_idx};
                    if (mem_rdata == 8'd0) begin
                        w_next = S_DONE;
                    end else if (mem_rdata > 8'd4) begin
                        w_next     = S_ERR;
                        w_err_code = ERR_BAD_CODE;
                    end else if (w_off_board) begin
                        w_next     = S_ERR;
                        w_err_code = ERR_OFF_EDGE;
                    end else begin
                        w_next = S_RD_NB;
                    end
                end
            end
            S_RD_NB: begin
                mem_addr = BOARD_A + {4'd0, r_nb};
                w_next   = S_WR_BLANK;
            end
            S_WR_BLANK: begin
                mem_addr  = BOARD_A + {4'd0, r_blank};
                mem_wdata = r_tile;
                mem_we    = 1'b1;
                w_next    = S_WR_NB;
            end
            S_WR_NB: begin
                mem_addr  = BOARD_A + {4'd0, r_nb};
                mem_wdata = 8'd0;
                mem_we    = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. The reset
        // is sampled at the clock edge, so it is a plain branch here rather
        // than being listed in the sensitivity list.
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_scan     <= 4'd0;
            r_blank    <= 4'd0;
            r_nb       <= 4'd0;
            r_idx      <= 6'd0;
            r_moves    <= 6'd0;
            r_tile     <= 8'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_code <= 2'd0;
                        r_moves    <= 6'd0;
                        r_idx      <= 6'd0;
                        r_scan     <= 4'd0;
                    end
                end
                S_SCAN: begin
                    if (mem_rdata == 8'd0) r_blank <= r_scan;
                    else if (r_scan != 4'd8) r_scan <= r_scan + 4'd1;
                end
                S_FETCH:    r_nb   <= w_nb;
                S_RD_NB:    r_tile <= mem_rdata;
                S_WR_NB: begin
                    r_blank <= r_nb;
                    r_moves <= r_moves + 6'd1;
                    r_idx   <= r_idx + 6'd1;
                end
                default: ;
            endcase
            // done/error rise on the same edge that busy falls.
            if (w_busy && w_next == S_DONE) r_done <= 1'b1;
            if (w_busy && w_next == S_ERR) begin
                r_error    <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

    assign busy       = w_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign err_code   = r_err_code;
    assign moves_done = r_moves;
    assign blank_pos  = r_blank;

endmodule

// File: tb/tb_puzzle_route_executor.sv
// -----------------------------------------------------------------------------
// tb_puzzle_route_executor
//
// Drives puzzle_route_executor against a 256x8 memory. The memory has a
// combinational read and a clocked write, and it clears on rst_n. Directed
// cases come first, followed by randomized boards and routes. Results are
// compared with a move-by-move reference model that works in row/column terms.
// -----------------------------------------------------------------------------
module tb_puzzle_route_executor;

    localparam int BOARD_BASE = 0;
    localparam int ROUTE_BASE = 16;
    localparam int ROUTE_LEN  = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [5:0] moves_done;
    logic [3:0] blank_pos;

    puzzle_route_executor #(
        .BOARD_BASE(BOARD_BASE),
        .ROUTE_BASE(ROUTE_BASE),
        .ROUTE_LEN (ROUTE_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .moves_done(moves_done),
        .blank_pos (blank_pos)
    );

    always #5 clk = ~clk;

    // Shared memory with a bench-side load port.
    logic [7:0] mem [256];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Current case: board and route image.
    logic [7:0] bd [9];
    logic [7:0] rt [32];

    // Model results.
    logic [7:0] eb [9];
    int e_moves, e_cyc, e_code, e_blank;
    bit e_done, e_err;

    // Blank at p moves with code 1..4. Returns the new index, or -1 if the move leaves the board.
    function automatic int step(input int p, input int code);
        int r = p / 3;
        int c = p % 3;
        case (code)
            1: r = r - 1;
            2: r = r + 1;
            3: c = c - 1;
            4: c = c + 1;
            default: return -1;
        endcase
        if (r < 0 || r > 2 || c < 0 || c > 2) return -1;
        return r * 3 + c;
    endfunction

    task automatic model();
        int  b = -1;
        int  nb;
        bit  stop = 0;
        for (int i = 0; i < 9; i++) begin
            eb[i] = bd[i];
            if (b < 0 && bd[i] == 8'd0) b = i;
        end
        e_moves = 0; e_done = 0; e_err = 0; e_code = 0;
        if (b < 0) begin
            e_err = 1; e_code = 1; e_cyc = 9;
        end else begin
            for (int k = 0; k < ROUTE_LEN && !stop; k++) begin
                if (rt[k] == 8'd0) begin
                    e_done = 1; stop = 1;
                end else if (rt[k] > 8'd4) begin
                    e_err = 1; e_code = 2; stop = 1;
                end else begin
                    nb = step(b, int'(rt[k]));
                    if (nb < 0) begin
                        e_err = 1; e_code = 3; stop = 1;
                    end else begin
                        eb[b]  = eb[nb];
                        eb[nb] = 8'd0;
                        b      = nb;
                        e_moves++;
                    end
                end
            end
            if (!stop) e_done = 1;
            e_cyc   = (e_blank_scan(bd)) + 4 * e_moves + 1;
            e_blank = b;
        end
    endtask

    function automatic int e_blank_scan(input logic [7:0] brd [9]);
        for (int i = 0; i < 9; i++) if (brd[i] == 8'd0) return i + 1;
        return 9;
    endfunction

    task automatic load_mem();
        for (int i = 0; i < 9 + ROUTE_LEN; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = (i < 9) ? 8'(BOARD_BASE + i) : 8'(ROUTE_BASE + i - 9);
            ld_data = (i < 9) ? bd[i] : rt[i - 9];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        check({pfx, "_busy"},  busy, 0);
        check({pfx, "_done"},  done, 0);
        check({pfx, "_error"}, error, 0);
        check({pfx, "_code"},  err_code, 0);
        check({pfx, "_moves"}, moves_done, 0);
        check({pfx, "_blank"}, blank_pos, 0);
        check({pfx, "_we"},    mem_we, 0);
        check({pfx, "_addr"},  mem_addr, 0);
        check({pfx, "_wdata"}, mem_wdata, 0);
    endtask

    task automatic run_case(input string name, input bit mid_start);
        int cyc = 0;
        int we_n = 0;
        bit past_rd = 0;
        model();
        load_mem();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({name, "_busy_rise"}, busy, 1);
        while (!(done || error) && cyc < 400) begin
            if (mem_we) we_n++;
            if (mem_addr == 8'(ROUTE_BASE + ROUTE_LEN)) past_rd = 1;
            start = (mid_start && cyc == 3);
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_finished"}, (done || error), 1);
        check({name, "_cycles"},   cyc, e_cyc);
        check({name, "_done"},     done, e_done);
        check({name, "_error"},    error, e_err);
        check({name, "_code"},     err_code, e_code);
        check({name, "_moves"},    moves_done, e_moves);
        check({name, "_blank"},    blank_pos, e_blank);
        check({name, "_busy"},     busy, 0);
        check({name, "_we_cnt"},   we_n, 2 * e_moves);
        check({name, "_past_end"}, past_rd, 0);
        for (int i = 0; i < 9; i++)
            check($sformatf("%s_cell%0d", name, i), mem[BOARD_BASE + i], eb[i]);
    endtask

    task automatic fill_route_random();
        for (int k = 0; k < ROUTE_LEN; k++) rt[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic random_case(input int n);
        int p = 0;
        int nb;
        int code;
        int x;
        logic [7:0] t;
        for (int i = 0; i < 9; i++) bd[i] = 8'(i);
        for (int i = 8; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            t = bd[i]; bd[i] = bd[j]; bd[j] = t;
        end
        if ($urandom_range(0, 7) == 0) begin
            for (int i = 0; i < 9; i++) if (bd[i] == 8'd0) bd[i] = 8'($urandom_range(1, 255));
        end
        for (int i = 0; i < 9; i++) if (bd[i] == 8'd0) p = i;
        // Mostly legal walks, with occasional terminators, bad codes and blind moves.
        for (int k = 0; k < ROUTE_LEN; k++) begin
            x = int'($urandom_range(0, 99));
            if (x < 3) rt[k] = 8'd0;
            else if (x < 6) rt[k] = 8'($urandom_range(5, 255));
            else if (x < 10) rt[k] = 8'($urandom_range(1, 4));
            else begin
                do begin
                    code = int'($urandom_range(1, 4));
                    nb   = step(p, code);
                end while (nb < 0);
                rt[k] = 8'(code);
                p = nb;
            end
        end
        run_case($sformatf("rnd%0d", n), 1'b0);
    endtask

    initial begin
        int guard;
        e_blank = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Two legal moves then terminator.
        bd = '{8'd2, 8'd6, 8'd4, 8'd3, 8'd5, 8'd1, 8'd7, 8'd8, 8'd0};
        fill_route_random();
        rt[0] = 8'd1; rt[1] = 8'd3; rt[2] = 8'd0;
        run_case("two_moves", 1'b0);
        check("two_moves_cyc_spec", e_cyc, 18);

        // Right from column 2 is off-board.
        fill_route_random();
        rt[0] = 8'd4;
        run_case("off_board", 1'b0);

        // One swap, then bad code.
        fill_route_random();
        rt[0] = 8'd1; rt[1] = 8'd9;
        run_case("bad_code", 1'b0);

        // No blank on the board.
        bd = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        fill_route_random();
        run_case("no_blank", 1'b0);

        // Full-length route without a terminator, with start pulsed while busy.
        bd = '{8'd2, 8'd6, 8'd4, 8'd3, 8'd5, 8'd1, 8'd7, 8'd8, 8'd0};
        for (int k = 0; k < ROUTE_LEN; k++) rt[k] = (k % 2 == 0) ? 8'd1 : 8'd2;
        run_case("full_route", 1'b1);

        // Reset during WR_BLANK of move 2, then rerun from scratch.
        fill_route_random();
        rt[0] = 8'd1; rt[1] = 8'd3; rt[2] = 8'd0;
        load_mem();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0;
        begin
            int we_seen = 0;
            while (we_seen < 3 && guard < 100) begin
                if (mem_we) we_seen++;
                if (we_seen < 3) begin
                    @(negedge clk);
                    guard++;
                end
            end
        end
        check("mid_reset_reached", (guard < 100), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        check("mid_reset_cell5", mem[BOARD_BASE + 5], 0);
        rst_n = 1'b1;
        e_blank = 0;
        run_case("after_reset", 1'b0);

        for (int n = 0; n < 25; n++) random_case(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
